// File: rtl/line_buf_pkg.sv
// rtl/line_buf_pkg.sv - shared state encoding and raster sizing helpers for the line-buffer video output
package line_buf_pkg;

    typedef enum logic [1:0] {
        WAIT_FILL = 2'd0,
        RUN       = 2'd1,
        STOP      = 2'd2
    } state_e;

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // A one-count raster still needs a 1-bit counter.
    function automatic int calc_cnt_w(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// rtl/video_timing_cnt.sv - horizontal/vertical raster counters with active and sync decode
module video_timing_cnt
    import line_buf_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    output logic o_act,
    output logic o_hs_pre,
    output logic o_vs_pre,
    output logic o_sof,
    output logic o_eof
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = calc_cnt_w(H_TOTAL);
    localparam int VW      = calc_cnt_w(V_TOTAL);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_last;
    logic          w_v_last;
    int            w_h_pos;
    int            w_v_pos;

    assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));

    // Counters sit at the origin whenever the raster is parked.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_run) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // Compare in int so sync windows ending exactly at 2**HW do not truncate.
    assign w_h_pos  = int'(r_h_cnt);
    assign w_v_pos  = int'(r_v_cnt);
    assign o_act    = i_run && (w_h_pos < H_ACTIVE) && (w_v_pos < V_ACTIVE);
    assign o_hs_pre = (w_h_pos >= H_ACTIVE + H_FP) && (w_h_pos < H_ACTIVE + H_FP + H_SYNC);
    assign o_vs_pre = (w_v_pos >= V_ACTIVE + V_FP) && (w_v_pos < V_ACTIVE + V_FP + V_SYNC);
    assign o_sof    = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_eof    = w_h_last && w_v_last;

endmodule

// File: rtl/line_buf_video_out.sv
// rtl/line_buf_video_out.sv - raster generator draining the line-buffer FIFO into a video pixel stream
module line_buf_video_out
    import line_buf_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                H_ACTIVE = 640,
    parameter int                H_FP     = 16,
    parameter int                H_SYNC   = 96,
    parameter int                H_BP     = 48,
    parameter int                V_ACTIVE = 480,
    parameter int                V_FP     = 10,
    parameter int                V_SYNC   = 2,
    parameter int                V_BP     = 33,
    parameter bit                SYNC_POL = 1'b0,
    parameter logic [DATA_W-1:0] FILL_VAL = '0
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              en,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    input  logic              fifo_almost_empty,
    output logic              vid_hs,
    output logic              vid_vs,
    output logic              vid_de,
    output logic [DATA_W-1:0] vid_data,
    output logic              frame_start,
    output logic              underflow,
    output logic [15:0]       underflow_cnt
);

    state_e      r_state;
    logic        w_run;
    logic        w_act;
    logic        w_hs_pre;
    logic        w_vs_pre;
    logic        w_sof;
    logic        w_eof;
    logic        r_de;
    logic        r_hs;
    logic        r_vs;
    logic        r_fs;
    logic        r_read_d;
    logic        r_underflow;
    logic [15:0] r_underflow_cnt;

    assign w_run = (r_state != WAIT_FILL);

    video_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk    (rd_clk),
        .i_rst    (rd_rst),
        .i_run    (w_run),
        .o_act    (w_act),
        .o_hs_pre (w_hs_pre),
        .o_vs_pre (w_vs_pre),
        .o_sof    (w_sof),
        .o_eof    (w_eof)
    );

    // Once running, a frame is always finished before re-priming.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_state <= WAIT_FILL;
        end else begin
            case (r_state)
                WAIT_FILL: if (en && !fifo_almost_empty) r_state <= RUN;
                RUN:       if (!en) r_state <= STOP;
                STOP:      if (w_eof) r_state <= WAIT_FILL;
                default:   r_state <= WAIT_FILL;
            endcase
        end
    end

    assign fifo_rd_en = w_act && !fifo_empty;

    // One register stage lines the raster up with the FIFO read latency.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_de            <= 1'b0;
            r_hs            <= ~SYNC_POL;
            r_vs            <= ~SYNC_POL;
            r_fs            <= 1'b0;
            r_read_d        <= 1'b0;
            r_underflow     <= 1'b0;
            r_underflow_cnt <= '0;
        end else begin
            r_de     <= w_act;
            r_hs     <= w_hs_pre ^ ~SYNC_POL;
            r_vs     <= w_vs_pre ^ ~SYNC_POL;
            r_fs     <= w_act && w_sof;
            r_read_d <= fifo_rd_en;
            if (w_act && fifo_empty) begin
                r_underflow <= 1'b1;
                if (r_underflow_cnt != 16'hFFFF) begin
                    r_underflow_cnt <= r_underflow_cnt + 16'd1;
                end
            end
        end
    end

    assign vid_de        = r_de;
    assign vid_hs        = r_hs;
    assign vid_vs        = r_vs;
    assign frame_start   = r_fs;
    assign underflow     = r_underflow;
    assign underflow_cnt = r_underflow_cnt;
    assign vid_data      = r_read_d ? fifo_rd_data : (r_de ? FILL_VAL : '0);

endmodule

// File: tb/tb_line_buf_video_out.sv
// tb/tb_line_buf_video_out.sv - self-checking bench for line_buf_video_out on an 8x5 raster
module tb_line_buf_video_out;

    localparam int H_TOTAL = 8;
    localparam int V_TOTAL = 5;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        en = 1'b1;
    logic        fifo_almost_empty = 1'b1;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        vid_hs;
    logic        vid_vs;
    logic        vid_de;
    logic [7:0]  vid_data;
    logic        frame_start;
    logic        underflow;
    logic [15:0] underflow_cnt;

    logic [7:0]  fifo_mem [0:63];
    int          fifo_wr = 0;
    int          fifo_rd = 0;
    logic [7:0]  exp_mem [0:63];
    int          exp_wr = 0;
    int          exp_rd = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    line_buf_video_out #(
        .DATA_W   (8),
        .H_ACTIVE (4),
        .H_FP     (1),
        .H_SYNC   (2),
        .H_BP     (1),
        .V_ACTIVE (2),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .SYNC_POL (1'b0),
        .FILL_VAL (8'h00)
    ) dut (
        .rd_clk            (rd_clk),
        .rd_rst            (rd_rst),
        .en                (en),
        .fifo_rd_en        (fifo_rd_en),
        .fifo_rd_data      (fifo_rd_data),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .vid_hs            (vid_hs),
        .vid_vs            (vid_vs),
        .vid_de            (vid_de),
        .vid_data          (vid_data),
        .frame_start       (frame_start),
        .underflow         (underflow),
        .underflow_cnt     (underflow_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: data appears one clock after the read enable.
    assign fifo_empty = (fifo_wr == fifo_rd);
    always @(posedge rd_clk) begin
        if (fifo_rd_en && (fifo_wr != fifo_rd)) begin
            fifo_rd_data <= fifo_mem[fifo_rd % 64];
            fifo_rd      <= fifo_rd + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic fifo_push(input logic [7:0] d);
        fifo_mem[fifo_wr % 64] = d;
        fifo_wr++;
    endtask

    task automatic exp_push(input logic [7:0] d);
        exp_mem[exp_wr % 64] = d;
        exp_wr++;
    endtask

    // Advance to the next falling edge and score any pixel presented there.
    task automatic tick();
        @(negedge rd_clk);
        if (vid_de) begin
            if (exp_rd == exp_wr) begin
                check("pix_unexpected", 32'(vid_de), 32'd0);
            end else begin
                check("pix", 32'(vid_data), 32'(exp_mem[exp_rd % 64]));
                exp_rd++;
            end
        end
    endtask

    task automatic start_frame();
        int lat;
        lat = 0;
        fifo_almost_empty = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (frame_start) begin
                lat = i;
                break;
            end
        end
        check("fs_latency", 32'(lat), 32'd2);
    endtask

    // Walk a whole frame from its frame_start, dropping en on line 1.
    task automatic run_frame(input int tid);
        int   h;
        int   v;
        logic e_de;
        logic e_hs;
        logic e_vs;
        for (int k = 0; k < FRAME; k++) begin
            h    = k % H_TOTAL;
            v    = k / H_TOTAL;
            e_de = (h < 4) && (v < 2);
            e_hs = !((h >= 5) && (h < 7));
            e_vs = (v != 3);
            check("de", 32'(vid_de), 32'(e_de));
            check("hs", 32'(vid_hs), 32'(e_hs));
            check("vs", 32'(vid_vs), 32'(e_vs));
            check("fs", 32'(frame_start), 32'(k == 0));
            if (tid == 3 && k == 2) check("rd_en_when_empty", 32'(fifo_rd_en), 32'd0);
            if (tid == 3 && k == 3) begin
                check("uf_set", 32'(underflow), 32'd1);
                check("uf_cnt_1", 32'(underflow_cnt), 32'd1);
            end
            if (tid == 3 && k == 4) begin
                for (int i = 0; i < 4; i++) begin
                    fifo_push(8'h30 + 8'(i));
                    exp_push(8'h30 + 8'(i));
                end
            end
            if (tid == 4 && k == 0) check("rd_en_uf", 32'(fifo_rd_en), 32'd0);
            if (tid == 4 && k <= 1) check("uf_cnt_sat", 32'(underflow_cnt), 32'hFFFF);
            if (k == 10) en = 1'b0;
            tick();
        end
    endtask

    initial begin
        // 1: reset with en=1, FIFO empty, then park while almost-empty
        for (int i = 0; i < 3; i++) tick();
        check("rst_de", 32'(vid_de), 32'd0);
        check("rst_data", 32'(vid_data), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_hs", 32'(vid_hs), 32'd1);
        check("rst_vs", 32'(vid_vs), 32'd1);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_uf", 32'(underflow), 32'd0);
        check("rst_uf_cnt", 32'(underflow_cnt), 32'd0);
        rd_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wait_de", 32'(vid_de), 32'd0);
            check("wait_rd_en", 32'(fifo_rd_en), 32'd0);
        end

        // 2 + 5: primed frame 0x10..0x17, en dropped on line 1
        for (int i = 0; i < 8; i++) begin
            fifo_push(8'h10 + 8'(i));
            exp_push(8'h10 + 8'(i));
        end
        start_frame();
        run_frame(2);
        for (int i = 0; i < 6; i++) begin
            check("stop_de", 32'(vid_de), 32'd0);
            check("stop_rd_en", 32'(fifo_rd_en), 32'd0);
            tick();
        end
        check("t2_uf", 32'(underflow), 32'd0);
        check("t2_uf_cnt", 32'(underflow_cnt), 32'd0);

        // 3: only three words at line start
        fifo_almost_empty = 1'b1;
        en = 1'b1;
        fifo_push(8'h20); fifo_push(8'h21); fifo_push(8'h22);
        exp_push(8'h20); exp_push(8'h21); exp_push(8'h22); exp_push(8'h00);
        start_frame();
        run_frame(3);
        check("t3_uf", 32'(underflow), 32'd1);
        check("t3_uf_cnt", 32'(underflow_cnt), 32'd1);

        // 4: counter preset near saturation, whole frame underflows
        fifo_almost_empty = 1'b1;
        en = 1'b1;
        force dut.r_underflow_cnt = 16'hFFFE;
        tick();
        release dut.r_underflow_cnt;
        tick();
        check("uf_cnt_preset", 32'(underflow_cnt), 32'hFFFE);
        for (int i = 0; i < 8; i++) exp_push(8'h00);
        start_frame();
        run_frame(4);
        check("t4_uf_cnt", 32'(underflow_cnt), 32'hFFFF);
        check("t4_uf", 32'(underflow), 32'd1);

        // 6: reset mid-line while vid_de is high
        fifo_almost_empty = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 8; i++) fifo_push(8'h40 + 8'(i));
        exp_push(8'h40); exp_push(8'h41);
        start_frame();
        tick();
        check("pre_rst_de", 32'(vid_de), 32'd1);
        rd_rst = 1'b1;
        tick();
        check("mid_rst_de", 32'(vid_de), 32'd0);
        check("mid_rst_data", 32'(vid_data), 32'd0);
        check("mid_rst_uf", 32'(underflow), 32'd0);
        check("mid_rst_uf_cnt", 32'(underflow_cnt), 32'd0);
        check("mid_rst_hs", 32'(vid_hs), 32'd1);
        check("mid_rst_vs", 32'(vid_vs), 32'd1);
        check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        fifo_almost_empty = 1'b1;
        en = 1'b0;
        tick();
        rd_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_de", 32'(vid_de), 32'd0);
            check("post_rst_fs", 32'(frame_start), 32'd0);
        end
        check("sb_drained", 32'(exp_wr - exp_rd), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
